// File: rtl/uart_cmd_pkg.sv
// Shared types and byte constants for the UART command parser.
// The index width helper keeps single-entry tables at a 1-bit index.
package uart_cmd_pkg;

   typedef enum logic [1:0] {
      COLLECT,
      POP_WAIT,
      MATCH,
      REPLY
   } state_t;

   localparam logic [7:0] ASCII_CR         = 8'h0D;
   localparam logic [7:0] ASCII_LF         = 8'h0A;
   localparam logic [7:0] REPLY_ACK        = 8'h41;
   localparam logic [7:0] REPLY_NAK        = 8'h4E;
   localparam logic [7:0] REPLY_NAK_ARG    = 8'h3F;
   localparam logic [7:0] REPLY_DIGIT_BASE = 8'h30;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/cmd_matcher.sv
// Combinational lookup of an assembled command in the parameter table.
// Entry 0 sits in the table MSBs; the lowest matching entry wins.
module cmd_matcher
   import uart_cmd_pkg::*;
#(
   parameter int                          CMD_LEN   = 4,
   parameter int                          NUM_CMDS  = 4,
   parameter logic [NUM_CMDS*CMD_LEN*8-1:0] CMD_TABLE = "TESTLEDSSPI0UART",
   localparam int                         IDX_W     = idx_width(NUM_CMDS)
) (
   input  logic [CMD_LEN*8-1:0] cmd_buf,
   output logic                 hit,
   output logic [IDX_W-1:0]     index
);

   // Scan from the top entry down so the lowest matching index is the last written.
   always_comb begin
      hit   = 1'b0;
      index = '0;
      for (int i = NUM_CMDS - 1; i >= 0; i--) begin
         if (cmd_buf == CMD_TABLE[(NUM_CMDS-1-i)*CMD_LEN*8 +: CMD_LEN*8]) begin
            hit   = 1'b1;
            index = IDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/uart_cmd_parser.sv
// Table-driven ASCII command parser sitting between the UART RX and TX FIFOs.
//
// state    | meaning
// COLLECT  | pop the next RX byte when available, store it (CR/LF at index 0 dropped)
// POP_WAIT | one idle cycle so the RX FIFO empty flag catches up after a pop
// MATCH    | compare the assembled command, pulse cmd_valid or cmd_error
// REPLY    | push the 4-byte ACK/NAK reply, stalling while the TX FIFO is full
module uart_cmd_parser
   import uart_cmd_pkg::*;
#(
   parameter int                            CMD_LEN        = 4,
   parameter int                            NUM_CMDS       = 4,
   parameter logic [NUM_CMDS*CMD_LEN*8-1:0] CMD_TABLE      = "TESTLEDSSPI0UART",
   parameter int                            TIMEOUT_CYCLES = 2700000,
   localparam int                           IDX_W          = idx_width(NUM_CMDS)
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             rx_fifo_empty,
   input  logic [7:0]       rx_fifo_data_out,
   output logic             rx_fifo_read_en,
   input  logic             tx_fifo_full,
   output logic [7:0]       tx_fifo_data_in,
   output logic             tx_fifo_write_en,
   output logic             cmd_valid,
   output logic [IDX_W-1:0] cmd_index,
   output logic             cmd_error,
   output logic             cmd_timeout,
   output logic             busy
);

   localparam int BUF_W = idx_width(CMD_LEN);
   localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [BUF_W-1:0] LAST_POS   = BUF_W'(CMD_LEN - 1);
   localparam logic [TO_W-1:0]  TO_RELOAD  = TO_W'(TIMEOUT_CYCLES - 1);

   state_t           state_q, state_d;
   logic [BUF_W-1:0] idx_q;
   logic [7:0]       cmd_bytes [CMD_LEN];
   logic [TO_W-1:0]  to_cnt_q;
   logic [1:0]       reply_cnt_q;
   logic             reply_hit_q;
   logic [IDX_W-1:0] cmd_index_q;

   logic [CMD_LEN*8-1:0] cmd_buf;
   logic                 match_hit;
   logic [IDX_W-1:0]     match_idx;

   logic rx_pop;
   logic store;
   logic to_running;
   logic to_fire;
   logic tx_push;
   logic reply_done;
   logic is_crlf;

   always_comb begin
      cmd_buf = '0;
      for (int i = 0; i < CMD_LEN; i++) begin
         cmd_buf[(CMD_LEN-1-i)*8 +: 8] = cmd_bytes[i];
      end
   end

   cmd_matcher #(
      .CMD_LEN   (CMD_LEN),
      .NUM_CMDS  (NUM_CMDS),
      .CMD_TABLE (CMD_TABLE)
   ) u_matcher (
      .cmd_buf (cmd_buf),
      .hit     (match_hit),
      .index   (match_idx)
   );

   assign is_crlf = (rx_fifo_data_out == ASCII_CR) || (rx_fifo_data_out == ASCII_LF);

   // Strobes are forced low while reset_n is asserted so nothing escapes during reset.
   always_comb begin
      state_d          = state_q;
      rx_pop           = 1'b0;
      store            = 1'b0;
      to_running       = 1'b0;
      to_fire          = 1'b0;
      tx_push          = 1'b0;
      reply_done       = 1'b0;
      cmd_valid        = 1'b0;
      cmd_error        = 1'b0;
      tx_fifo_data_in  = 8'h00;
      if (reset_n) begin
         to_running = ((state_q == COLLECT) || (state_q == POP_WAIT)) &&
                      (idx_q != '0) && rx_fifo_empty;
         to_fire    = to_running && (to_cnt_q == '0);
         case (state_q)
            COLLECT: begin
               if (!rx_fifo_empty) begin
                  rx_pop = 1'b1;
                  if ((idx_q == '0) && is_crlf) begin
                     state_d = POP_WAIT;
                  end else begin
                     store   = 1'b1;
                     state_d = (idx_q == LAST_POS) ? MATCH : POP_WAIT;
                  end
               end
            end
            POP_WAIT: begin
               state_d = COLLECT;
            end
            MATCH: begin
               cmd_valid = match_hit;
               cmd_error = !match_hit;
               state_d   = REPLY;
            end
            REPLY: begin
               case (reply_cnt_q)
                  2'd0:    tx_fifo_data_in = reply_hit_q ? REPLY_ACK : REPLY_NAK;
                  2'd1:    tx_fifo_data_in = reply_hit_q ? (REPLY_DIGIT_BASE + 8'(cmd_index_q))
                                                         : REPLY_NAK_ARG;
                  2'd2:    tx_fifo_data_in = ASCII_CR;
                  default: tx_fifo_data_in = ASCII_LF;
               endcase
               if (!tx_fifo_full) begin
                  tx_push = 1'b1;
                  if (reply_cnt_q == 2'd3) begin
                     reply_done = 1'b1;
                     state_d    = COLLECT;
                  end
               end
            end
            default: state_d = COLLECT;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q     <= COLLECT;
         idx_q       <= '0;
         to_cnt_q    <= '0;
         reply_cnt_q <= '0;
         reply_hit_q <= 1'b0;
         cmd_index_q <= '0;
         for (int i = 0; i < CMD_LEN; i++) begin
            cmd_bytes[i] <= 8'h00;
         end
      end else begin
         state_q <= state_d;

         // Down-counter reloads on every pop and fires at terminal count zero.
         if (rx_pop) begin
            to_cnt_q <= TO_RELOAD;
         end else if (to_running && (to_cnt_q != '0)) begin
            to_cnt_q <= to_cnt_q - 1'b1;
         end

         if (store) begin
            cmd_bytes[idx_q] <= rx_fifo_data_out;
            if (idx_q != LAST_POS) begin
               idx_q <= idx_q + 1'b1;
            end
         end

         if (to_fire || reply_done) begin
            idx_q <= '0;
         end

         if (state_q == MATCH) begin
            reply_hit_q <= match_hit;
            if (match_hit) begin
               cmd_index_q <= match_idx;
            end
         end

         if (tx_push) begin
            reply_cnt_q <= reply_done ? 2'd0 : reply_cnt_q + 2'd1;
         end
      end
   end

   assign rx_fifo_read_en  = rx_pop;
   assign tx_fifo_write_en = tx_push;
   assign cmd_timeout      = to_fire;
   assign cmd_index        = cmd_index_q;
   assign busy             = (idx_q != '0) || (state_q == MATCH) || (state_q == REPLY);

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser with FWFT FIFO models on both sides.
// Expected replies, indices and cycle distances are hand-derived constants.
module tb_uart_cmd_parser;

   logic       clock;
   logic       reset_n;
   logic       rx_fifo_empty;
   logic [7:0] rx_fifo_data_out;
   logic       rx_fifo_read_en;
   logic       tx_fifo_full;
   logic [7:0] tx_fifo_data_in;
   logic       tx_fifo_write_en;
   logic       cmd_valid;
   logic [1:0] cmd_index;
   logic       cmd_error;
   logic       cmd_timeout;
   logic       busy;

   uart_cmd_parser #(
      .CMD_LEN        (4),
      .NUM_CMDS       (4),
      .CMD_TABLE      ("TESTLEDSSPI0UART"),
      .TIMEOUT_CYCLES (100)
   ) dut (
      .clock            (clock),
      .reset_n          (reset_n),
      .rx_fifo_empty    (rx_fifo_empty),
      .rx_fifo_data_out (rx_fifo_data_out),
      .rx_fifo_read_en  (rx_fifo_read_en),
      .tx_fifo_full     (tx_fifo_full),
      .tx_fifo_data_in  (tx_fifo_data_in),
      .tx_fifo_write_en (tx_fifo_write_en),
      .cmd_valid        (cmd_valid),
      .cmd_index        (cmd_index),
      .cmd_error        (cmd_error),
      .cmd_timeout      (cmd_timeout),
      .busy             (busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int         n_checks = 0;
   int         n_fail   = 0;
   logic [7:0] rx_q [$];
   logic [7:0] tx_log [$];
   int         cyc = 0;
   int         n_pops, n_valid, n_error, n_timeout, n_wr_full;
   int         last_pop_cyc, valid_cyc, timeout_cyc, first_push_cyc;
   int         n_consec = 0;
   logic       prev_rd = 1'b0;

   task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic rx_update();
      rx_fifo_empty    = (rx_q.size() == 0);
      rx_fifo_data_out = (rx_q.size() == 0) ? 8'h00 : rx_q[0];
   endtask

   task automatic rx_push(input string s);
      for (int i = 0; i < s.len(); i++) rx_q.push_back(s[i]);
      rx_update();
   endtask

   task automatic clr_stats();
      n_pops = 0; n_valid = 0; n_error = 0; n_timeout = 0; n_wr_full = 0;
      last_pop_cyc = -1; valid_cyc = -1; timeout_cyc = -1; first_push_cyc = -1;
      tx_log.delete();
   endtask

   // Observe at the negedge (values the DUT acts on), then advance the FIFOs after the edge.
   task automatic tick();
      logic rd;
      logic [7:0] tmp;
      @(negedge clock);
      rd = rx_fifo_read_en;
      if (rd) begin n_pops++; last_pop_cyc = cyc; end
      if (rd && prev_rd) n_consec++;
      prev_rd = rd;
      if (cmd_valid)   begin n_valid++;   valid_cyc   = cyc; end
      if (cmd_error)   n_error++;
      if (cmd_timeout) begin n_timeout++; timeout_cyc = cyc; end
      if (tx_fifo_write_en) begin
         if (tx_fifo_full) n_wr_full++;
         tx_log.push_back(tx_fifo_data_in);
         if (tx_log.size() == 1) first_push_cyc = cyc;
      end
      @(posedge clock);
      #1;
      if (rd && rx_q.size() > 0) tmp = rx_q.pop_front();
      rx_update();
      cyc++;
   endtask

   function automatic logic [31:0] tx_at(input int i);
      return (i < tx_log.size()) ? {24'h0, tx_log[i]} : 32'hDEAD;
   endfunction

   task automatic chk_tx(input string tag, input logic [31:0] e0, input logic [31:0] e1);
      logic [31:0] exp [4];
      exp[0] = e0; exp[1] = e1; exp[2] = 32'h0D; exp[3] = 32'h0A;
      chk_val({tag, "_ntx"}, tx_log.size(), 4);
      for (int i = 0; i < 4; i++) chk_val($sformatf("%s_tx%0d", tag, i), tx_at(i), exp[i]);
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk_val({tag, "_rd"},    rx_fifo_read_en,  0);
      chk_val({tag, "_wr"},    tx_fifo_write_en, 0);
      chk_val({tag, "_valid"}, cmd_valid,        0);
      chk_val({tag, "_idx"},   cmd_index,        0);
      chk_val({tag, "_err"},   cmd_error,        0);
      chk_val({tag, "_tmo"},   cmd_timeout,      0);
      chk_val({tag, "_busy"},  busy,             0);
   endtask

   initial begin
      reset_n = 1'b0;
      tx_fifo_full = 1'b0;
      rx_update();
      clr_stats();
      repeat (3) tick();
      chk_idle_outputs("rst");
      reset_n = 1'b1;

      // 1: TEST hits entry 0, one-cycle match latency then reply
      clr_stats(); rx_push("TEST"); repeat (30) tick();
      chk_val("t1_valid", n_valid, 1);
      chk_val("t1_err",   n_error, 0);
      chk_val("t1_idx",   cmd_index, 0);
      chk_val("t1_lat_valid", valid_cyc - last_pop_cyc, 1);
      chk_val("t1_lat_push",  first_push_cyc - last_pop_cyc, 2);
      chk_tx("t1", 32'h41, 32'h30);
      chk_val("t1_busy", busy, 0);

      // 2: near miss and case mismatch both NAK
      clr_stats(); rx_push("TESX"); repeat (30) tick();
      chk_val("t2_err",   n_error, 1);
      chk_val("t2_valid", n_valid, 0);
      chk_tx("t2", 32'h4E, 32'h3F);
      clr_stats(); rx_push("test"); repeat (30) tick();
      chk_val("t2b_err", n_error, 1);
      chk_val("t2b_idx_held", cmd_index, 0);

      // 3: leading CR/LF dropped
      clr_stats(); rx_q.push_back(8'h0D); rx_q.push_back(8'h0A); rx_push("LEDS");
      repeat (36) tick();
      chk_val("t3_pops",  n_pops, 6);
      chk_val("t3_valid", n_valid, 1);
      chk_val("t3_idx",   cmd_index, 1);
      chk_tx("t3", 32'h41, 32'h31);

      // 4: partial command times out, then a fresh command parses
      clr_stats(); rx_push("TE"); repeat (5) tick();
      chk_val("t4_busy_partial", busy, 1);
      repeat (115) tick();
      chk_val("t4_tmo_count", n_timeout, 1);
      chk_val("t4_tmo_dist",  timeout_cyc - last_pop_cyc, 100);
      chk_val("t4_ntx",       tx_log.size(), 0);
      chk_val("t4_busy_after", busy, 0);
      clr_stats(); rx_push("SPI0"); repeat (30) tick();
      chk_val("t4_valid", n_valid, 1);
      chk_val("t4_idx",   cmd_index, 2);
      chk_tx("t4", 32'h41, 32'h32);

      // 5: TX back-pressure for 20 cycles from the first reply byte
      clr_stats(); rx_push("LEDS");
      for (int k = 0; k < 30 && n_valid == 0; k++) tick();
      chk_val("t5_valid", n_valid, 1);
      tx_fifo_full = 1'b1;
      repeat (20) tick();
      chk_val("t5_ntx_full", tx_log.size(), 0);
      tx_fifo_full = 1'b0;
      repeat (20) tick();
      chk_val("t5_wr_full", n_wr_full, 0);
      chk_val("t5_first_push", first_push_cyc - valid_cyc, 21);
      chk_tx("t5", 32'h41, 32'h31);

      // 6: reset mid-command discards it
      clr_stats(); rx_push("UA"); repeat (6) tick();
      chk_val("t6_busy_partial", busy, 1);
      reset_n = 1'b0;
      tick();
      chk_idle_outputs("t6_rst");
      reset_n = 1'b1;
      clr_stats(); rx_push("UART"); repeat (30) tick();
      chk_val("t6_valid", n_valid, 1);
      chk_val("t6_err",   n_error, 0);
      chk_val("t6_tmo",   n_timeout, 0);
      chk_val("t6_idx",   cmd_index, 3);
      chk_tx("t6", 32'h41, 32'h33);
      chk_val("rd_consecutive", n_consec, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
